// File: rtl/fft_input_loader.sv
// fft_input_loader: frame-buffering producer for the radix-2 FFT core.
//
// Samples arrive one per cycle on a valid/ready stream. They are packed into
// even/odd pairs and stored in an N/2-entry pair RAM. Once a frame is complete,
// the loader pulses start_o and then streams all N/2 pairs on consecutive
// cycles. It then waits for a rising edge on fft_ready_i before it accepts
// the next frame.
//
// Optional feature macro: FFT_LOADER_ZEROPAD_EN
//   When defined, the s_last_i port is present. A short frame ended by
//   s_last_i is zero-padded out to N samples in the PAD state.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   s_re_i, s_im_i         sample real/imaginary parts (32 bit)
//   s_valid_i, s_ready_o   sample handshake
//   s_last_i               short-frame terminator (FFT_LOADER_ZEROPAD_EN only)
//   fft_ready_i            core done flag; a rising edge ends a transform
//   start_o                one-cycle start pulse to the core
//   pair_valid_o           x0/x1 carry a pair this cycle
//   x0_*_o, x1_*_o         even (x0) and odd (x1) sample of the current pair
//   busy_o                 high in START, SEND and WAIT
//   state_o                debug: FILL=0, PAD=1, START=2, SEND=3, WAIT=4
module fft_input_loader #(
  parameter int unsigned N = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_re_i,
  input  logic [31:0] s_im_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
`ifdef FFT_LOADER_ZEROPAD_EN
  input  logic        s_last_i,
`endif
  input  logic        fft_ready_i,
  output logic        start_o,
  output logic        pair_valid_o,
  output logic [31:0] x0_re_o,
  output logic [31:0] x0_im_o,
  output logic [31:0] x1_re_o,
  output logic [31:0] x1_im_o,
  output logic        busy_o,
  output logic [2:0]  state_o
);

  localparam int unsigned DW     = 32;
  localparam int unsigned PAIRS  = N / 2;
  localparam int unsigned ADDR_W = $clog2(PAIRS);
  localparam int unsigned K_W    = $clog2(N);

  typedef struct packed {
    logic [DW-1:0] x0_re;
    logic [DW-1:0] x0_im;
    logic [DW-1:0] x1_re;
    logic [DW-1:0] x1_im;
  } pair_t;

  typedef enum logic [2:0] {
    FILL  = 3'd0,
    PAD   = 3'd1,
    START = 3'd2,
    SEND  = 3'd3,
    WAIT  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [2*DW-1:0]     hold_q, hold_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                fr_q, fr_d;
  logic                s_ready_q, s_ready_d;
  logic                start_q, start_d;
  logic                pv_q, pv_d;
  logic                busy_q, busy_d;
  pair_t               pair_q;
`ifdef FFT_LOADER_ZEROPAD_EN
  // One bit wider than a RAM address so "all pairs written" is representable.
  logic [ADDR_W:0]     pad_q, pad_d;
`endif

  logic                accept_c;
  logic                wr_en_c;
  logic [ADDR_W-1:0]   wr_addr_c;
  pair_t               wr_data_c;
  logic                rd_en_c;
  logic [ADDR_W-1:0]   rd_addr_c;

  pair_t               mem_q [PAIRS];

  assign accept_c = s_valid_i && s_ready_q;

  // Next-state, RAM control and next-output logic.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    hold_d    = hold_q;
    rd_addr_d = rd_addr_q;
    fr_d      = fft_ready_i;
`ifdef FFT_LOADER_ZEROPAD_EN
    pad_d     = pad_q;
`endif
    wr_en_c   = 1'b0;
    wr_addr_c = ADDR_W'(k_q >> 1);
    wr_data_c = pair_t'({hold_q, s_re_i, s_im_i});
    rd_en_c   = 1'b0;
    rd_addr_c = rd_addr_q;

    case (state_q)
      FILL: begin
        if (accept_c) begin
          k_d = k_q + K_W'(1);
          if (k_q[0] == 1'b0) begin
            hold_d = {s_re_i, s_im_i};
          end else begin
            wr_en_c = 1'b1;
          end
          if (k_q == K_W'(N - 1)) begin
            state_d = START;
          end
`ifdef FFT_LOADER_ZEROPAD_EN
          else if (s_last_i) begin
            // Short frame: close the current pair, then zero-fill the rest.
            if (k_q[0] == 1'b0) begin
              wr_en_c   = 1'b1;
              wr_data_c = pair_t'({s_re_i, s_im_i, (2*DW)'(0)});
            end
            k_d     = '0;
            pad_d   = (ADDR_W+1)'(k_q >> 1) + (ADDR_W+1)'(1);
            state_d = PAD;
          end
`endif
        end
      end
`ifdef FFT_LOADER_ZEROPAD_EN
      PAD: begin
        if (pad_q == (ADDR_W+1)'(PAIRS)) begin
          state_d = START;
        end else begin
          wr_en_c   = 1'b1;
          wr_addr_c = pad_q[ADDR_W-1:0];
          wr_data_c = '0;
          pad_d     = pad_q + (ADDR_W+1)'(1);
          if (pad_q == (ADDR_W+1)'(PAIRS - 1)) begin
            state_d = START;
          end
        end
      end
`endif
      START: begin
        rd_en_c   = 1'b1;
        rd_addr_c = '0;
        rd_addr_d = ADDR_W'(1);
        state_d   = SEND;
      end
      SEND: begin
        rd_en_c   = 1'b1;
        rd_addr_d = rd_addr_q + ADDR_W'(1);
        if (rd_addr_q == ADDR_W'(PAIRS - 1)) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Only a genuine rising edge releases; a level held high does not.
        if (fft_ready_i && !fr_q) begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase

    s_ready_d = (state_d == FILL);
    start_d   = (state_d == START);
    busy_d    = (state_d == START) || (state_d == SEND) || (state_d == WAIT);
    pv_d      = rd_en_c;
  end

  // State and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      k_q       <= '0;
      hold_q    <= '0;
      rd_addr_q <= '0;
      fr_q      <= 1'b0;
      s_ready_q <= 1'b0;
      start_q   <= 1'b0;
      pv_q      <= 1'b0;
      busy_q    <= 1'b0;
`ifdef FFT_LOADER_ZEROPAD_EN
      pad_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      hold_q    <= hold_d;
      rd_addr_q <= rd_addr_d;
      fr_q      <= fr_d;
      s_ready_q <= s_ready_d;
      start_q   <= start_d;
      pv_q      <= pv_d;
      busy_q    <= busy_d;
`ifdef FFT_LOADER_ZEROPAD_EN
      pad_q     <= pad_d;
`endif
    end
  end

  // Pair RAM write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_addr_c] <= wr_data_c;
    end
  end

  // Registered RAM read doubles as the x0/x1 output register (holds when idle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_q <= '0;
    end else if (rd_en_c) begin
      pair_q <= mem_q[rd_addr_c];
    end
  end

  assign s_ready_o    = s_ready_q;
  assign start_o      = start_q;
  assign pair_valid_o = pv_q;
  assign busy_o       = busy_q;
  assign state_o      = state_q;
  assign x0_re_o      = pair_q.x0_re;
  assign x0_im_o      = pair_q.x0_im;
  assign x1_re_o      = pair_q.x1_re;
  assign x1_im_o      = pair_q.x1_im;

endmodule

// File: tb/tb_fft_input_loader.sv
// Scoreboard testbench for fft_input_loader with N=8.
// Stimulus pushes expected pairs into a queue; a monitor pops and compares
// whenever pair_valid_o is seen. Define FFT_LOADER_ZEROPAD_EN to also
// exercise short frames.
module tb_fft_input_loader;

  localparam int unsigned N = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_re_i, s_im_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic        last_drv;
  logic        fft_ready_i;
  logic        start_o, pair_valid_o, busy_o;
  logic [31:0] x0_re_o, x0_im_o, x1_re_o, x1_im_o;
  logic [2:0]  state_o;

  int errors = 0;
  int checks = 0;

  logic [127:0] exp_q[$];
  logic [127:0] last_exp = '0;
  bit           prev_pv = 1'b0;
  bit           prev_start = 1'b0;
  int           run = 0;

  fft_input_loader #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_re_i       (s_re_i),
    .s_im_i       (s_im_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
`ifdef FFT_LOADER_ZEROPAD_EN
    .s_last_i     (last_drv),
`endif
    .fft_ready_i  (fft_ready_i),
    .start_o      (start_o),
    .pair_valid_o (pair_valid_o),
    .x0_re_o      (x0_re_o),
    .x0_im_o      (x0_im_o),
    .x1_re_o      (x1_re_o),
    .x1_im_o      (x1_im_o),
    .busy_o       (busy_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: compare every presented pair against the scoreboard queue.
  always @(negedge clk) begin
    if (rst) begin
      run = 0;
    end else if (pair_valid_o) begin
      if (!prev_pv) chk("pv_follows_start", 128'(prev_start), 128'(1));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pair: got %h with empty scoreboard",
                 {x0_re_o, x0_im_o, x1_re_o, x1_im_o});
      end else begin
        last_exp = exp_q.pop_front();
        chk("pair", {x0_re_o, x0_im_o, x1_re_o, x1_im_o}, last_exp);
      end
      run++;
    end else if (prev_pv) begin
      chk("pv_run_len", 128'(run), 128'(N / 2));
      run = 0;
    end
    prev_pv    = pair_valid_o;
    prev_start = start_o;
  end

  // Send cnt samples re=base+k, im=-(base+k); optionally push expected pairs.
  task automatic send_frame(input int base, input int cnt, input bit gap,
                            input bit mark_last, input bit push);
    logic [31:0] re_m [N];
    logic [31:0] im_m [N];
    bit ok;
    for (int i = 0; i < int'(N); i++) begin
      re_m[i] = '0;
      im_m[i] = '0;
    end
    @(posedge clk); #1;
    for (int k = 0; k < cnt; k++) begin
      s_re_i    = 32'(base + k);
      s_im_i    = 32'(-(base + k));
      s_valid_i = 1'b1;
      last_drv  = mark_last && (k == cnt - 1);
      ok = 1'b0;
      for (int t = 0; t < 64 && !ok; t++) begin
        @(negedge clk);
        ok = s_ready_o;
        @(posedge clk); #1;
      end
      chk("accept", 128'(ok), 128'(1));
      re_m[k]   = 32'(base + k);
      im_m[k]   = 32'(-(base + k));
      s_valid_i = 1'b0;
      last_drv  = 1'b0;
      if (gap && k != cnt - 1) begin
        @(posedge clk); #1;
      end
    end
    if (push) begin
      for (int j = 0; j < int'(N / 2); j++)
        exp_q.push_back({re_m[2*j], im_m[2*j], re_m[2*j+1], im_m[2*j+1]});
    end
  endtask

  // Full-frame end: start pulse right after the last accept, one cycle wide.
  task automatic check_start();
    @(negedge clk);
    chk("start_pulse", 128'(start_o), 128'(1));
    chk("start_state", 128'(state_o), 128'(2));
    chk("start_busy", 128'(busy_o), 128'(1));
    chk("start_ready", 128'(s_ready_o), 128'(0));
    @(negedge clk);
    chk("start_width", 128'(start_o), 128'(0));
  endtask

  // Wait for the scoreboard to drain, then check the WAIT-state outputs.
  task automatic drain_and_check_wait();
    bit done = 1'b0;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !pair_valid_o;
    end
    chk("drained", 128'(done), 128'(1));
    chk("wait_state", 128'(state_o), 128'(4));
    chk("wait_ready", 128'(s_ready_o), 128'(0));
    chk("wait_busy", 128'(busy_o), 128'(1));
    chk("x_hold", {x0_re_o, x0_im_o, x1_re_o, x1_im_o}, last_exp);
  endtask

  // Low for a cycle, then a rising edge: ready one cycle later.
  task automatic release_wait();
    @(posedge clk); #1 fft_ready_i = 1'b0;
    @(posedge clk); #1 fft_ready_i = 1'b1;
    @(negedge clk);
    chk("ready_pre_release", 128'(s_ready_o), 128'(0));
    @(negedge clk);
    chk("ready_post_release", 128'(s_ready_o), 128'(1));
    chk("fill_state", 128'(state_o), 128'(0));
    chk("fill_busy", 128'(busy_o), 128'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 128'(s_ready_o), 128'(0));
    chk({tag, "_start"}, 128'(start_o), 128'(0));
    chk({tag, "_pv"}, 128'(pair_valid_o), 128'(0));
    chk({tag, "_x"}, {x0_re_o, x0_im_o, x1_re_o, x1_im_o}, 128'(0));
    chk({tag, "_busy"}, 128'(busy_o), 128'(0));
    chk({tag, "_state"}, 128'(state_o), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_re_i = '0; s_im_i = '0; s_valid_i = 1'b0;
    last_drv = 1'b0; fft_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_before_edge", 128'(s_ready_o), 128'(0));
    @(negedge clk);
    chk("ready_after_edge", 128'(s_ready_o), 128'(1));

    // Frame A: continuous valid.
    send_frame(0, N, 1'b0, 1'b0, 1'b1);
    check_start();
    drain_and_check_wait();
    release_wait();

    // Frame B: valid toggling every other cycle.
    send_frame(16, N, 1'b1, 1'b0, 1'b1);
    check_start();
    drain_and_check_wait();
    release_wait();

    // Frame C: fft_ready_i held high throughout; level must not release WAIT.
    send_frame(32, N, 1'b0, 1'b0, 1'b1);
    check_start();
    drain_and_check_wait();
    repeat (4) @(negedge clk);
    chk("no_release_state", 128'(state_o), 128'(4));
    chk("no_release_ready", 128'(s_ready_o), 128'(0));
    release_wait();

    // Partial frame aborted by reset, then a clean frame.
    send_frame(100, 5, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midreset_ready_before", 128'(s_ready_o), 128'(0));
    @(negedge clk);
    chk("midreset_ready_after", 128'(s_ready_o), 128'(1));
    send_frame(48, N, 1'b0, 1'b0, 1'b1);
    check_start();
    drain_and_check_wait();

`ifdef FFT_LOADER_ZEROPAD_EN
    // Short frame ended on k=2: expect (64,65),(66,0),(0,0),(0,0).
    release_wait();
    send_frame(64, 3, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("pad_state", 128'(state_o), 128'(1));
    for (int t = 0; t < 8 && state_o == 3'd1; t++) @(negedge clk);
    chk("pad_to_start", 128'(state_o), 128'(2));
    chk("pad_start_pulse", 128'(start_o), 128'(1));
    drain_and_check_wait();

    // s_last_i on k=N-1 behaves as a normal frame end.
    release_wait();
    send_frame(80, N, 1'b0, 1'b1, 1'b1);
    check_start();
    drain_and_check_wait();
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_input_loader.md
# fft_input_loader

Frame-buffering producer for the radix-2 FFT core. Accepts complex samples one per cycle on a valid/ready stream and packs them into even/odd pairs in an internal N/2-entry pair RAM. Once a full frame is held, it pulses start to the core and drives all N/2 pairs on consecutive cycles. It then waits for the core to signal completion before accepting the next frame. It sits between the sample source and the FFT core's start_i/x0/x1 load inputs.

## Interface
- N, 1024: transform length in samples; a power of two, at least 4.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_re_i  in  32  sample real part.
- s_im_i  in  32  sample imaginary part.
- s_valid_i  in  1  sample valid.
- s_ready_o  out  1  loader accepts a sample when s_valid_i && s_ready_o.
- s_last_i  in  1  last sample of a short frame; present only with FFT_LOADER_ZEROPAD_EN.
- fft_ready_i  in  1  core done flag; a rising edge ends a transform.
- start_o  out  1  one-cycle start pulse to the core.
- pair_valid_o  out  1  x0/x1 outputs carry a pair this cycle.
- x0_re_o, x0_im_o, x1_re_o, x1_im_o  out  32 each  even sample (x0) and odd sample (x1) of pair j.
- busy_o  out  1  high in START, SEND and WAIT.
- state_o  out  3  debug encoding: FILL=0, PAD=1, START=2, SEND=3, WAIT=4.

## Operation
- Sample counter k counts 0..N-1.
- Even k: sample latched in the hold register.
- Odd k: {hold, sample} written to RAM address k>>1.
- Pair RAM is N/2 x 128 bits with a registered read.
- FILL: s_ready_o=1.
  - Acceptance of k=N-1 -> START.
  - k wraps to 0.
- START: one cycle.
  - start_o=1, s_ready_o=0.
  - RAM read address 0 issued; read address counter set to 1 -> SEND.
- SEND: one RAM read per cycle, addresses 1..N/2-1.
  - Registered data drives x0/x1 with pair_valid_o=1.
  - After read N/2-1 is issued and its data presented -> WAIT.
- WAIT: s_ready_o=0.
  - fft_ready_i sampled into fr_q (reset 0).
  - fft_ready_i && !fr_q -> FILL.
- fft_ready_i high on entry to WAIT without a rising edge does not release WAIT.
- The stream stalls when s_ready_o=0; no sample is dropped or duplicated.
- x0/x1 outputs hold their last values when pair_valid_o=0.
- Reset, including mid-frame: state FILL, k=0, hold and output registers 0, fr_q=0. RAM contents are don't-care; the partial frame is discarded.

## Timing
- Reset values: s_ready_o=0, start_o=0, pair_valid_o=0, all x outputs 0, busy_o=0, state_o=0.
- s_ready_o rises on the first clock edge after rst deasserts.
- Last sample accepted at edge E: start_o high in cycle E+1; pairs j=0..N/2-1 valid in cycles E+2+j.
- pair_valid_o is continuous for exactly N/2 cycles, with no gaps.
- Earliest next acceptance: the cycle after the fft_ready_i rising edge is registered.
- Frame-to-frame minimum: N + 1 + N/2 cycles + core compute time + 1.

## Configuration
- FFT_LOADER_ZEROPAD_EN defined:
  - s_last_i port exists.
  - Accepted sample with s_last_i=1 and k<N-1 -> PAD; s_ready_o=0.
  - Last on even k: write {sample, 0} at k>>1.
  - Last on odd k: write the normal pair.
  - PAD then writes one zero pair per cycle up to address N/2-1, then -> START.
  - s_last_i at k=N-1 behaves as a normal frame end.
- FFT_LOADER_ZEROPAD_EN undefined:
  - No s_last_i port and no PAD state.
  - Frames are exactly N samples.

## Test plan
- N=8, sample k with re=k, im=-k, s_valid_i held 1:
  - 8 accepts, then start_o for 1 cycle.
  - Pairs (0,1),(2,3),(4,5),(6,7) on 4 consecutive cycles starting the cycle after start_o.
  - s_ready_o=0 afterwards.
- Source toggles s_valid_i every other cycle:
  - Identical pair sequence.
  - start_o 1 cycle after the 8th accept.
- Hold fft_ready_i=1 through WAIT: no release. Drop to 0, then raise to 1: s_ready_o=1 one cycle later; the second frame's pairs are correct.
- Assert rst after 5 samples:
  - All outputs return to reset values.
  - A following full 8-sample frame produces pairs from the new samples only.
- ZEROPAD build, N=8, s_last_i on k=2:
  - Pairs (0,1),(2,0),(0,0),(0,0).
  - state_o shows 1 before 2.
- ZEROPAD build, s_last_i on k=7: identical to the no-last case; PAD is never entered.
